mm_arb: RTL and testbench
=========================

Name: mm_arb

Overview:
- Two-client arbiter in front of the memory module; it shares that module's single write port and read port 0.
- Client A is the CPU core load/store path. Client B is the program loader/debug path.
- Grants at most one access (read or write) per cycle, round-robin, using a valid/ready request handshake.
- Read data returns one cycle after grant through a registered response. Read port 1 is not owned by this block and is wired elsewhere.

Parameters:
- WORD_W, 8, data word width; must match the memory module.
- ADDR_W, 4, address width; must match the memory module.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- a_valid  in  1  client A request valid.
- a_ready  out  1  client A request accepted this cycle (combinational).
- a_we  in  1  client A request is a write (1) or a read (0).
- a_addr  in  ADDR_W  client A address.
- a_wdata  in  WORD_W  client A write data.
- a_lock  in  1  client A holds the grant after this transfer (only with MM_ARB_LOCK_EN).
- a_rvalid  out  1  client A read response valid (registered, 1-cycle pulse).
- a_rdata  out  WORD_W  client A read data (registered, held between responses).
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as the A ports, for client B; B has no lock input.
- mm_we  out  1  to memory module write enable.
- mm_waddr  out  ADDR_W  to memory module write address.
- mm_wdata  out  WORD_W  to memory module write data.
- mm_raddr0  out  ADDR_W  to memory module read port 0 address.
- mm_rdata0  in  WORD_W  from memory module read port 0 data (asynchronous).

Behaviour:
- Reset is synchronous and active-low: while rst_n=0 at posedge clk, state is cleared.
  - last_grant <= B, so A wins the first contention.
  - a_rvalid and b_rvalid <= 0; a_rdata and b_rdata <= 0; lock <= 0.
  - Combinationally during rst_n=0: a_ready=b_ready=0 and mm_we=0.
- Grant selection (combinational):
  - Only one client valid: that client is granted.
  - Both valid: grant the client that is not last_grant.
  - Neither valid: no grant.
- Handshake:
  - x_ready=1 only for the granted client.
  - A transfer occurs when x_valid && x_ready.
  - Clients hold their request fields stable while valid and not ready.
- Memory port drive:
  - mm_waddr = mm_raddr0 = granted addr (A's addr when idle).
  - mm_wdata = granted wdata.
  - mm_we = transfer && granted we.
- Write: committed at the same posedge as the transfer; no response is generated.
- Read: mm_rdata0 is sampled at the transfer posedge into x_rdata, and x_rvalid=1 for exactly the next cycle. Latency from accept to data is 1 cycle.
- Back-to-back: a client may transfer every cycle when uncontended. Under continuous contention, grants alternate A,B,A,B.
- last_grant updates to the granted client on every transfer. It does not change on idle cycles.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. Same-cycle read and write cannot occur (single grant).
- Reset asserted mid-read: the pending x_rvalid is suppressed and x_rdata is cleared.

Optional Feature:
- Macro: MM_ARB_LOCK_EN.
- Defined:
  - An A transfer with a_lock=1 sets lock. While lock=1, A is always granted and b_ready=0.
  - Lock clears on the next A transfer with a_lock=0; that transfer itself is still granted to A.
  - Lock is cleared by reset.
  - Intended for read-modify-write sequences.
- Undefined: a_lock is ignored, no lock state exists, and arbitration is pure round-robin.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, mm_we=0, rvalid=0, rdata=0 throughout. First cycle after release: a_ready=1, b_ready=0.
- A writes 0x5A to addr 3, then reads addr 3 the next cycle -> mm_we=1 only on the write cycle; a_rvalid=1 one cycle after the read accept with a_rdata=0x5A; b_rvalid stays 0.
- Contention: both hold valid reads (A addr 1, B addr 2) for 4 cycles -> grants A,B,A,B; rvalids alternate one cycle later with the correct data per address.
- B alone issues 4 back-to-back writes (addr 0..3, data 0x10..0x13) -> b_ready=1 every cycle; memory then reads back 0x10..0x13.
- Reset asserted on the cycle after an A read accept -> a_rvalid never rises, a_rdata=0.
- MM_ARB_LOCK_EN defined:
  - A reads addr 4 with a_lock=1, then writes 0x77 to addr 4 with a_lock=0, while b_valid=1 throughout.
  - Required: b_ready=0 during both A transfers; B is granted on the cycle after the unlock.
  - Same stimulus without the macro: B is granted between the two A transfers.

Source files
------------

// File: rtl/mm_arb.sv
// mm_arb: two-client round-robin arbiter in front of the memory module.
// It shares the memory's single write port and read port 0 between
// client A (CPU load/store) and client B (program loader / debug).
// At most one access (read or write) is granted per cycle.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   a_* / b_*         valid/ready request channel per client; read data
//                     returns one cycle after the accept (x_rvalid pulse)
//   a_lock            keep A granted after this transfer (lock build only)
//   mm_we, mm_waddr, mm_wdata   memory write port
//   mm_raddr0, mm_rdata0        memory read port 0 (asynchronous read)
//
// Configuration macro: MM_ARB_LOCK_EN
//   defined   - an A transfer with a_lock=1 locks the grant to A until the
//               next A transfer with a_lock=0 (read-modify-write support)
//   undefined - a_lock is ignored; pure round-robin arbitration
module mm_arb #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_rvalid,
  output logic [WORD_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WORD_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [WORD_W-1:0] b_rdata,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_waddr,
  output logic [WORD_W-1:0] mm_wdata,
  output logic [ADDR_W-1:0] mm_raddr0,
  input  logic [WORD_W-1:0] mm_rdata0
);

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  logic              last_grant_r;
  logic              a_rvalid_r;
  logic              b_rvalid_r;
  logic [WORD_W-1:0] a_rdata_r;
  logic [WORD_W-1:0] b_rdata_r;
  logic              grant_a;
  logic              grant_b;
  logic              xfer_a;
  logic              xfer_b;
  logic              lock_active;

`ifdef MM_ARB_LOCK_EN
  logic lock_r;
  assign lock_active = lock_r;
`else
  logic unused_lock;
  assign unused_lock = a_lock;
  assign lock_active = 1'b0;
`endif

  // Grant selection: lock first, then round-robin on contention, else the lone requester.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst_n) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end else if (lock_active) begin
      grant_a = 1'b1;
    end else if (a_valid && b_valid) begin
      if (last_grant_r == GNT_B) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else if (a_valid) begin
      grant_a = 1'b1;
    end else if (b_valid) begin
      grant_b = 1'b1;
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign xfer_a  = a_valid & grant_a;
  assign xfer_b  = b_valid & grant_b;

  // Memory port follows the granted client; A's fields are presented when idle.
  assign mm_waddr  = grant_b ? b_addr  : a_addr;
  assign mm_raddr0 = grant_b ? b_addr  : a_addr;
  assign mm_wdata  = grant_b ? b_wdata : a_wdata;
  assign mm_we     = (xfer_a & a_we) | (xfer_b & b_we);

  // Responses are gated by reset so a read pending when reset arrives never shows.
  assign a_rvalid = a_rvalid_r & rst_n;
  assign b_rvalid = b_rvalid_r & rst_n;
  assign a_rdata  = rst_n ? a_rdata_r : {WORD_W{1'b0}};
  assign b_rdata  = rst_n ? b_rdata_r : {WORD_W{1'b0}};

  // Arbitration history, lock state and registered read responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= GNT_B;
      a_rvalid_r   <= 1'b0;
      b_rvalid_r   <= 1'b0;
      a_rdata_r    <= {WORD_W{1'b0}};
      b_rdata_r    <= {WORD_W{1'b0}};
`ifdef MM_ARB_LOCK_EN
      lock_r       <= 1'b0;
`endif
    end else begin
      a_rvalid_r <= xfer_a & ~a_we;
      b_rvalid_r <= xfer_b & ~b_we;
      if (xfer_a && !a_we) begin
        a_rdata_r <= mm_rdata0;
      end else begin
        a_rdata_r <= a_rdata_r;
      end
      if (xfer_b && !b_we) begin
        b_rdata_r <= mm_rdata0;
      end else begin
        b_rdata_r <= b_rdata_r;
      end
      if (xfer_a) begin
        last_grant_r <= GNT_A;
      end else if (xfer_b) begin
        last_grant_r <= GNT_B;
      end else begin
        last_grant_r <= last_grant_r;
      end
`ifdef MM_ARB_LOCK_EN
      // Each A transfer sets or releases the lock; the releasing transfer is still A's.
      if (xfer_a) begin
        lock_r <= a_lock;
      end else begin
        lock_r <= lock_r;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mm_arb.sv
// Self-checking bench for mm_arb: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model that
// tracks the round-robin preference, lock, expected responses and memory.
module tb_mm_arb;
  localparam int WORD_W = 8;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              a_valid, a_ready, a_we, a_lock, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [WORD_W-1:0] a_wdata, a_rdata;
  logic              b_valid, b_ready, b_we, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [WORD_W-1:0] b_wdata, b_rdata;
  logic              mm_we;
  logic [ADDR_W-1:0] mm_waddr, mm_raddr0;
  logic [WORD_W-1:0] mm_wdata, mm_rdata0;

  mm_arb #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_lock(a_lock), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mm_we(mm_we), .mm_waddr(mm_waddr), .mm_wdata(mm_wdata),
    .mm_raddr0(mm_raddr0), .mm_rdata0(mm_rdata0)
  );

  // Memory module stand-in: synchronous write, asynchronous read.
  logic [WORD_W-1:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) if (mm_we) mem[mm_waddr] <= mm_wdata;
  assign mm_rdata0 = mem[mm_raddr0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic              m_pref_a;     // 1: A wins the next contention
  logic              m_lock;
  logic              m_arv, m_brv;
  logic [WORD_W-1:0] m_ard, m_brd;
  logic [WORD_W-1:0] ref_mem [16] = '{default: 8'h00};
  logic              e_ga, e_gb;
  // Observed values from the last step, for directed checks
  logic              obs_ar, obs_br, obs_we, obs_arv, obs_brv;
  logic [WORD_W-1:0] obs_ard, obs_brd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pref_a = 1'b1;
    m_lock   = 1'b0;
    m_arv    = 1'b0;
    m_brv    = 1'b0;
    m_ard    = '0;
    m_brd    = '0;
  endtask

  // One clock: check the DUT mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    logic ta, tb;
    logic [ADDR_W-1:0] e_addr;
    #3;
    if (!rst_n) begin
      e_ga = 1'b0; e_gb = 1'b0;
    end else if (m_lock) begin
      e_ga = 1'b1; e_gb = 1'b0;
    end else if (a_valid && b_valid) begin
      e_ga = m_pref_a; e_gb = !m_pref_a;
    end else begin
      e_ga = a_valid; e_gb = b_valid;
    end
    ta = a_valid && e_ga;
    tb = b_valid && e_gb;
    e_addr = e_gb ? b_addr : a_addr;
    obs_ar = a_ready; obs_br = b_ready; obs_we = mm_we;
    obs_arv = a_rvalid; obs_brv = b_rvalid; obs_ard = a_rdata; obs_brd = b_rdata;
    chk("a_ready", a_ready, e_ga);
    chk("b_ready", b_ready, e_gb);
    chk("mm_we", mm_we, (ta && a_we) || (tb && b_we));
    chk("mm_waddr", mm_waddr, e_addr);
    chk("mm_raddr0", mm_raddr0, e_addr);
    if (ta && a_we) chk("mm_wdata_a", mm_wdata, a_wdata);
    if (tb && b_we) chk("mm_wdata_b", mm_wdata, b_wdata);
    chk("a_rvalid", a_rvalid, rst_n ? m_arv : 1'b0);
    chk("b_rvalid", b_rvalid, rst_n ? m_brv : 1'b0);
    chk("a_rdata", a_rdata, rst_n ? m_ard : 8'h00);
    chk("b_rdata", b_rdata, rst_n ? m_brd : 8'h00);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_arv = ta && !a_we;
      m_brv = tb && !b_we;
      if (ta && !a_we) m_ard = ref_mem[a_addr];
      if (tb && !b_we) m_brd = ref_mem[b_addr];
      if (ta && a_we) ref_mem[a_addr] = a_wdata;
      if (tb && b_we) ref_mem[b_addr] = b_wdata;
      if (ta) m_pref_a = 1'b0;
      if (tb) m_pref_a = 1'b1;
`ifdef MM_ARB_LOCK_EN
      if (ta) m_lock = a_lock;
`endif
    end
    #1;
  endtask

  initial begin
    logic done, b_between, a_stall, b_stall;
    rst_n = 1'b0;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'hAA; a_lock = 1'b0;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'hBB;
    @(posedge clk); #1;
    model_reset();

    // Reset held with both clients requesting writes
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_ready", obs_ar, 1'b0);
      chk("rst_mm_we", obs_we, 1'b0);
    end
    rst_n = 1'b1; a_we = 1'b0; b_we = 1'b0;
    step();
    chk("rel_a_ready", obs_ar, 1'b1);
    chk("rel_b_ready", obs_br, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // A write then read-after-write
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h5A;
    step();
    chk("raw_wr_we", obs_we, 1'b1);
    a_we = 1'b0;
    step();
    chk("raw_rd_we", obs_we, 1'b0);
    a_valid = 1'b0;
    step();
    chk("raw_rvalid", obs_arv, 1'b1);
    chk("raw_rdata", obs_ard, 8'h5A);
    chk("raw_b_rvalid", obs_brv, 1'b0);

    // B alone once so A wins the following contention
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    step();
    b_valid = 1'b0;
    step();

    // Continuous contention: A,B,A,B
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cont_grant_a", obs_ar, (k % 2) == 0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // B back-to-back writes, then A reads them back
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_we = 1'b1; b_addr = 4'(i); b_wdata = 8'(8'h10 + i);
      step();
      chk("bw_ready", obs_br, 1'b1);
    end
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_valid = (i < 4); a_we = 1'b0; a_addr = 4'(i % 4);
      step();
      if (i > 0) chk("bw_readback", obs_ard, 8'(8'h10 + i - 1));
    end

    // Reset arriving right after an A read accept
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    step();
    a_valid = 1'b0; rst_n = 1'b0;
    step();
    chk("rst_mid_rvalid", obs_arv, 1'b0);
    chk("rst_mid_rdata", obs_ard, 8'h00);
    rst_n = 1'b1;
    step();
    chk("rst_mid_rvalid_after", obs_arv, 1'b0);
    chk("rst_mid_rdata_after", obs_ard, 8'h00);

    // Lock sequence: A read (lock=1) then A write (lock=0) with B requesting throughout
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd5;
    step();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd4; a_lock = 1'b1;
    step();
    chk("lk_rd_a_ready", obs_ar, 1'b1);
    chk("lk_rd_b_ready", obs_br, 1'b0);
    a_we = 1'b1; a_wdata = 8'h77; a_lock = 1'b0;
    done = 1'b0; b_between = 1'b0;
    for (int w = 0; w < 4 && !done; w++) begin
      step();
      if (obs_br) b_between = 1'b1;
      if (obs_ar) done = 1'b1;
    end
    chk("lk_wr_done", done, 1'b1);
    a_valid = 1'b0;
    step();
`ifdef MM_ARB_LOCK_EN
    chk("lk_b_blocked", b_between, 1'b0);
    chk("lk_b_after_unlock", obs_br, 1'b1);
`else
    chk("nolk_b_between", b_between, 1'b1);
`endif
    b_valid = 1'b0;
    step();

    // Random traffic with occasional reset; requests stay stable until accepted
    a_stall = 1'b0; b_stall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      if (!a_stall) begin
        a_valid = $urandom_range(0, 2) != 0;
        a_we    = $urandom_range(0, 1) != 0;
        a_addr  = 4'($urandom_range(0, 15));
        a_wdata = 8'($urandom_range(0, 255));
        a_lock  = $urandom_range(0, 3) == 0;
      end
      if (!b_stall) begin
        b_valid = $urandom_range(0, 2) != 0;
        b_we    = $urandom_range(0, 1) != 0;
        b_addr  = 4'($urandom_range(0, 15));
        b_wdata = 8'($urandom_range(0, 255));
      end
      step();
      a_stall = a_valid && !e_ga;
      b_stall = b_valid && !e_gb;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
